up_dn_counter: RTL and testbench

- Loadable, saturating up/down counter, WIDTH bits (5 by default).
- Combinational flags report when the count is at its maximum (High) or at zero (Low).
- General-purpose counting/limit-detect primitive, driven from a single clock domain.
- Control priority: reset > Load > Down > Up > hold.

---
 rtl/up_dn_counter.sv | 41 ++++
 tb/tb_up_dn_counter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/up_dn_counter.sv
// Loadable saturating up/down counter with max/zero flags.
// Priority: reset > load > down > up > hold; never wraps.
module up_dn_counter #(
  parameter int WIDTH = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN,
  input  logic             Load,
  input  logic             Up,
  input  logic             Down,
  output logic [WIDTH-1:0] Counter,
  output logic             High,
  output logic             Low
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [WIDTH-1:0] next;

  // Down wins over Up; each direction stalls at its own limit.
  always_comb begin
    next = Counter;
    if (Load) begin
      next = IN;
    end else if (Down) begin
      if (!Low) next = Counter - 1'b1;
    end else if (Up) begin
      if (!High) next = Counter + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) Counter <= '0;
    else      Counter <= next;
  end

  assign High = (Counter == MAX_VAL);
  assign Low  = (Counter == '0);

endmodule

// File: tb/tb_up_dn_counter.sv
// Bench for up_dn_counter: directed vector table plus
// randomized traffic against an arithmetic reference model.
module tb_up_dn_counter;

  localparam int W   = 5;
  localparam int MAX = (1 << W) - 1;

  logic         clk;
  logic         rst;
  logic [W-1:0] in;
  logic         load;
  logic         up;
  logic         down;
  logic [W-1:0] counter;
  logic         high;
  logic         low;

  int checks;
  int errors;

  typedef struct {
    bit         rst_n;
    bit         ld;
    bit         u;
    bit         d;
    logic [W-1:0] din;
    int         exp;
  } vec_t;

  vec_t vq[$];

  up_dn_counter #(.WIDTH(W)) dut (
    .CLK(clk),
    .RST(rst),
    .IN(in),
    .Load(load),
    .Up(up),
    .Down(down),
    .Counter(counter),
    .High(high),
    .Low(low)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  function automatic void add(input bit r, input bit l, input bit u,
                              input bit d, input int din, input int e);
    vec_t v;
    v.rst_n = r;
    v.ld    = l;
    v.u     = u;
    v.d     = d;
    v.din   = din[W-1:0];
    v.exp   = e;
    vq.push_back(v);
  endfunction

  task automatic step(input bit r, input bit l, input bit u, input bit d,
                      input logic [W-1:0] din);
    @(negedge clk);
    rst  = r;
    load = l;
    up   = u;
    down = d;
    in   = din;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input int exp);
    chk({name, ".cnt"}, {27'd0, counter}, exp);
    chk({name, ".high"}, {31'd0, high}, (exp == MAX) ? 1 : 0);
    chk({name, ".low"}, {31'd0, low}, (exp == 0) ? 1 : 0);
  endtask

  initial begin
    int model;
    bit r, l, u, d;
    logic [W-1:0] din;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    load = 1'b0;
    up = 1'b0;
    down = 1'b0;
    in = '0;

    add(0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 16, 16);
    for (int i = 1; i <= 5; i++) add(1, 0, 1, 0, 0, 16 + i);
    for (int i = 0; i < 24; i++)
      add(1, 0, 1, 1, 0, (i < 21) ? 20 - i : 0);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0);
    add(1, 1, 1, 0, MAX, MAX);
    for (int i = 0; i < 3; i++) add(1, 0, 1, 0, 0, MAX);
    add(1, 1, 1, 1, MAX, MAX);
    add(1, 1, 0, 0, 10, 10);
    add(0, 1, 1, 0, 25, 0);
    add(1, 1, 0, 0, 25, 25);
    add(1, 0, 0, 1, 0, 24);

    foreach (vq[i]) begin
      step(vq[i].rst_n, vq[i].ld, vq[i].u, vq[i].d, vq[i].din);
      check_all($sformatf("vec%0d", i), vq[i].exp);
    end

    model = 25 - 1;
    for (int i = 0; i < 2000; i++) begin
      r   = ($urandom_range(0, 31) != 0);
      l   = ($urandom_range(0, 7) == 0);
      u   = $urandom_range(0, 1);
      d   = ($urandom_range(0, 2) == 0);
      din = W'($urandom_range(0, MAX));
      if ($urandom_range(0, 15) == 0) din = (i % 2) ? W'(MAX) : '0;
      step(r, l, u, d, din);
      if (!r)     model = 0;
      else if (l) model = din;
      else if (d) model = (model > 0) ? model - 1 : 0;
      else if (u) model = (model < MAX) ? model + 1 : MAX;
      check_all($sformatf("rnd%0d", i), model);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
